// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - sequences 2x2 windows from the input buffer through a pooling unit into the output buffer
// Optional feature: define POOL_CTRL_RELU_EN to clamp negative pooled results to zero on write.
module pool_ctrl #(
    parameter int BUF_WIDTH  = 26,
    parameter int FM_SIZE    = 24,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [BUF_WIDTH-1:0]   rd_data,
    output logic                   pool_start,
    output logic [4*BUF_WIDTH-1:0] pool_ifm,
    input  logic [BUF_WIDTH-1:0]   pool_ofm,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [BUF_WIDTH-1:0]   wr_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_FIRE, S_WAIT, S_WR, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] L_FM   = ADDR_WIDTH'(FM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] L_HALF = ADDR_WIDTH'(FM_SIZE / 2);
    localparam logic [ADDR_WIDTH-1:0] L_LAST = ADDR_WIDTH'(FM_SIZE - 2);
    localparam logic [ADDR_WIDTH-1:0] L_TWO  = ADDR_WIDTH'(2);

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_WIDTH-1:0]  r_row;
    logic [ADDR_WIDTH-1:0]  r_col;
    logic [1:0]             r_k;
    logic [4*BUF_WIDTH-1:0] r_ifm;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [BUF_WIDTH-1:0]   w_result;
    logic                   w_last;

    assign w_last    = (r_row == L_LAST) && (r_col == L_LAST);
    // k[0] selects the right-hand column, k[1] the lower row of the window
    assign w_rd_addr = r_row * L_FM + r_col + (r_k[1] ? L_FM : '0) + ADDR_WIDTH'(r_k[0]);
    assign w_wr_addr = (r_row >> 1) * L_HALF + (r_col >> 1);

`ifdef POOL_CTRL_RELU_EN
    assign w_result = pool_ofm[BUF_WIDTH-1] ? '0 : pool_ofm;
`else
    assign w_result = pool_ofm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        pool_start = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RD;
            end
            S_RD: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = w_rd_addr;
                if (r_k == 2'd3) w_next = S_CAP;
            end
            S_CAP: begin
                busy   = 1'b1;
                w_next = S_FIRE;
            end
            S_FIRE: begin
                busy       = 1'b1;
                pool_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                busy   = 1'b1;
                w_next = S_WR;
            end
            S_WR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = w_wr_addr;
                wr_data = w_result;
                w_next  = w_last ? S_DONE : S_RD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Read data lags the address by a cycle, so RD k captures slot k-1 and CAP captures slot 3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
            r_ifm <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_row <= '0;
                r_col <= '0;
                r_k   <= '0;
            end
            if (r_state == S_RD) begin
                r_k <= r_k + 2'd1;
            end
            for (int s = 0; s < 3; s++) begin
                if (r_state == S_RD && r_k == 2'(s + 1)) begin
                    r_ifm[s*BUF_WIDTH +: BUF_WIDTH] <= rd_data;
                end
            end
            if (r_state == S_CAP) begin
                r_ifm[3*BUF_WIDTH +: BUF_WIDTH] <= rd_data;
            end
            if (r_state == S_WR) begin
                if (r_col == L_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + L_TWO;
                end else begin
                    r_col <= r_col + L_TWO;
                end
            end
        end
    end

    assign pool_ifm = r_ifm;

endmodule
